fifo_byte_serializer: RTL and testbench

Read-side drain stage for the 32-bit FIFO buffer. Pops one word at a time from the FIFO and emits it as a stream of bytes, MSB first, over a valid/ready handshake toward a byte-wide consumer such as a UART or SPI transmitter. It owns the FIFO `RD` strobe, observes `EMPTY`, and counts the words it has delivered.

---
 rtl/fifo_byte_serializer.sv | 109 ++++++++++
 tb/tb_fifo_byte_serializer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops words from a FIFO and emits them MSB-first as BYTE_WIDTH beats.
// Latency: first beat valid 2 cycles after the pop decision; NBEATS+2 cycles per word at full rate.
// Backpressure: a beat is held stable until byte_ready; no new pop is issued until the word drains.
//
// Ports:
//   Clk, Rst        clock and synchronous active-high reset
//   En, EMPTY       pop permission and FIFO empty flag
//   dataOut, RD     FIFO read data (valid the cycle after RD) and read strobe
//   byte_out, byte_valid, byte_ready, byte_last   beat stream toward the consumer
//   busy            state is not IDLE
//   word_count      words fully delivered, wraps silently
module fifo_byte_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] dataOut,
    output logic                  RD,
    output logic [BYTE_WIDTH-1:0] byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  byte_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int NBEATS = DATA_WIDTH / BYTE_WIDTH;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [BW-1:0]         beat_q;
    logic                  hs;
    logic                  last_beat;

    // All handshake-facing outputs are pure decodes of registered state,
    // so byte_valid never looks at byte_ready.
    assign RD         = (state_q == READ);
    assign byte_valid = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign byte_last  = byte_valid && last_beat;
    assign byte_out   = shreg_q[DATA_WIDTH-1 -: BYTE_WIDTH];
    assign hs         = byte_valid && byte_ready;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (En && !EMPTY) begin
                    state_nxt = READ;
                end
            end
            READ: state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: begin
                // EMPTY is only looked at here and in IDLE; chaining straight
                // into READ gives the back-to-back pop with no idle cycle.
                if (hs && last_beat) begin
                    state_nxt = (En && !EMPTY) ? READ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            beat_q     <= '0;
            word_count <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                LOAD: begin
                    shreg_q <= dataOut;
                    beat_q  <= '0;
                end
                SEND: begin
                    if (hs) begin
                        if (last_beat) begin
                            word_count <= word_count + CNT_WIDTH'(1);
                        end else begin
                            shreg_q <= shreg_q << BYTE_WIDTH;
                            beat_q  <= beat_q + BW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer: directed bench for fifo_byte_serializer with a small FIFO model.
// Latency: inputs change and outputs are sampled on the falling edge.
// Backpressure: byte_ready is driven per scenario.
module tb_fifo_byte_serializer;

    logic        Clk;
    logic        Rst;
    logic        En;
    logic        EMPTY;
    logic [31:0] dataOut;
    logic        RD;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        busy;
    logic [3:0]  word_count;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model: pushes from the stimulus process, pops on RD.
    logic [31:0] mem [32];
    int          wr_ptr   = 0;
    int          rd_ptr   = 0;
    logic        fifo_clr = 1'b0;

    // Monitor state
    logic [7:0] cap_byte [256];
    logic       cap_last [256];
    int         nbytes    = 0;
    int         n_last    = 0;
    int         rd_cnt    = 0;
    int         underflow = 0;

    fifo_byte_serializer #(
        .DATA_WIDTH(32),
        .BYTE_WIDTH(8),
        .CNT_WIDTH (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .EMPTY     (EMPTY),
        .dataOut   (dataOut),
        .RD        (RD),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_last (byte_last),
        .busy      (busy),
        .word_count(word_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    assign EMPTY = (wr_ptr == rd_ptr);

    always @(posedge Clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (RD === 1'b1 && wr_ptr != rd_ptr) begin
            dataOut <= mem[rd_ptr % 32];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    always @(posedge Clk) begin
        if (RD === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            if (EMPTY && !fifo_clr) underflow <= underflow + 1;
        end
        if (Rst === 1'b0 && byte_valid === 1'b1 && byte_ready === 1'b1) begin
            cap_byte[nbytes % 256] <= byte_out;
            cap_last[nbytes % 256] <= byte_last;
            nbytes <= nbytes + 1;
            if (byte_last === 1'b1) n_last <= n_last + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 32] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        En = 1'b0;
        byte_ready = 1'b1;
        fifo_clr = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        fifo_clr = 1'b0;
    endtask

    // Waits (bounded) until the serializer has left IDLE and come back.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (i >= 2 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_words(input int target, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_last - base >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        En = 1'b0;
        byte_ready = 1'b1;
        fifo_clr = 1'b1;
        tick();
        n_checks++; if (RD !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", RD); end
        n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", byte_valid); end
        n_checks++; if (byte_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", byte_last); end
        n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", byte_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (word_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", word_count); end
        tick();
        Rst = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic test_single_word();
        logic [6:0]  e_rd;
        logic [6:0]  e_vld;
        logic [6:0]  e_busy;
        logic [6:0]  e_last;
        logic [31:0] w;
        logic [7:0]  eb;
        int          rd0;
        int          b0;
        e_rd   = 7'b0000001;
        e_vld  = 7'b0111100;
        e_busy = 7'b0111111;
        e_last = 7'b0100000;
        w      = 32'h11223344;
        do_reset();
        rd0 = rd_cnt;
        b0  = nbytes;
        push(w);
        En = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_checks++; if (RD !== e_rd[k]) begin n_fail++; $display("FAIL single_rd c%0d: got %b expected %b", k, RD, e_rd[k]); end
            n_checks++; if (byte_valid !== e_vld[k]) begin n_fail++; $display("FAIL single_valid c%0d: got %b expected %b", k, byte_valid, e_vld[k]); end
            n_checks++; if (busy !== e_busy[k]) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", k, busy, e_busy[k]); end
            n_checks++; if (byte_last !== e_last[k]) begin n_fail++; $display("FAIL single_last c%0d: got %b expected %b", k, byte_last, e_last[k]); end
            if (k >= 2 && k <= 5) begin
                eb = w[31 - 8 * (k - 2) -: 8];
                n_checks++; if (byte_out !== eb) begin n_fail++; $display("FAIL single_byte c%0d: got %h expected %h", k, byte_out, eb); end
            end
        end
        tick();
        tick();
        n_checks++; if (word_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", word_count); end
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL single_rd_pulses: got %0d expected 1", rd_cnt - rd0); end
        n_checks++; if (nbytes - b0 !== 4) begin n_fail++; $display("FAIL single_nbytes: got %0d expected 4", nbytes - b0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        logic [7:0]  eb;
        int          rd0;
        int          b0;
        bit          ok;
        w = 32'h11223344;
        do_reset();
        rd0 = rd_cnt;
        b0  = nbytes;
        push(w);
        En = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        byte_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (byte_out !== 8'h22) begin n_fail++; $display("FAIL bp_hold_byte c%0d: got %h expected 22", k, byte_out); end
            n_checks++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d: got %b expected 1", k, byte_valid); end
            if (k < 3) tick();
        end
        byte_ready = 1'b1;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: busy %b expected 0", busy); end
        n_checks++; if (nbytes - b0 !== 4) begin n_fail++; $display("FAIL bp_nbytes: got %0d expected 4", nbytes - b0); end
        for (int i = 0; i < 4; i++) begin
            eb = w[31 - 8 * i -: 8];
            n_checks++; if (cap_byte[b0 + i] !== eb) begin n_fail++; $display("FAIL bp_order b%0d: got %h expected %h", i, cap_byte[b0 + i], eb); end
            n_checks++; if (cap_last[b0 + i] !== (i == 3)) begin n_fail++; $display("FAIL bp_last b%0d: got %b expected %b", i, cap_last[b0 + i], (i == 3)); end
        end
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL bp_rd_pulses: got %0d expected 1", rd_cnt - rd0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_b [8];
        int         b0;
        e_b[0] = 8'h00; e_b[1] = 8'h00; e_b[2] = 8'h00; e_b[3] = 8'h01;
        e_b[4] = 8'h00; e_b[5] = 8'h00; e_b[6] = 8'h00; e_b[7] = 8'h02;
        do_reset();
        b0 = nbytes;
        push(32'h00000001);
        push(32'h00000002);
        En = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            n_checks++; if (RD !== (k == 0 || k == 6)) begin n_fail++; $display("FAIL b2b_rd c%0d: got %b expected %b", k, RD, (k == 0 || k == 6)); end
            if (k == 11) begin
                n_checks++; if (word_count !== 4'd1) begin n_fail++; $display("FAIL b2b_count_c11: got %0d expected 1", word_count); end
            end
            if (k == 12) begin
                n_checks++; if (word_count !== 4'd2) begin n_fail++; $display("FAIL b2b_count_c12: got %0d expected 2", word_count); end
            end
        end
        n_checks++; if (nbytes - b0 !== 8) begin n_fail++; $display("FAIL b2b_nbytes: got %0d expected 8", nbytes - b0); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (cap_byte[b0 + i] !== e_b[i]) begin n_fail++; $display("FAIL b2b_beat b%0d: got %h expected %h", i, cap_byte[b0 + i], e_b[i]); end
            n_checks++; if (cap_last[b0 + i] !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL b2b_last b%0d: got %b expected %b", i, cap_last[b0 + i], (i == 3 || i == 7)); end
        end
    endtask

    task automatic test_empty_en_gating();
        logic [31:0] w;
        logic [7:0]  eb;
        int          rd0;
        int          b0;
        bit          ok;
        w = 32'hA0B0C0D0;
        do_reset();
        En = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++; if (RD !== 1'b0) begin n_fail++; $display("FAIL empty_rd c%0d: got %b expected 0", k, RD); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy c%0d: got %b expected 0", k, busy); end
        end
        rd0 = rd_cnt;
        b0  = nbytes;
        push(w);
        push(32'h55555555);
        for (int k = 0; k < 4; k++) tick();
        n_checks++; if (byte_out !== 8'hB0) begin n_fail++; $display("FAIL en_beat1: got %h expected b0", byte_out); end
        En = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL en_timeout: busy %b expected 0", busy); end
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (nbytes - b0 !== 4) begin n_fail++; $display("FAIL en_nbytes: got %0d expected 4", nbytes - b0); end
        for (int i = 0; i < 4; i++) begin
            eb = w[31 - 8 * i -: 8];
            n_checks++; if (cap_byte[b0 + i] !== eb) begin n_fail++; $display("FAIL en_beat b%0d: got %h expected %h", i, cap_byte[b0 + i], eb); end
        end
        n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL en_rd_pulses: got %0d expected 1", rd_cnt - rd0); end
        n_checks++; if (word_count !== 4'd1) begin n_fail++; $display("FAIL en_count: got %0d expected 1", word_count); end
        n_checks++; if (EMPTY !== 1'b0) begin n_fail++; $display("FAIL en_fifo_left: EMPTY %b expected 0", EMPTY); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_idle: busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_word();
        int b0;
        do_reset();
        b0 = nbytes;
        push(32'hDEADBEEF);
        En = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        n_checks++; if (byte_out !== 8'hDE) begin n_fail++; $display("FAIL rst_first: got %h expected de", byte_out); end
        tick();
        Rst = 1'b1;
        tick();
        n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", byte_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (word_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", word_count); end
        Rst = 1'b0;
        En = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (nbytes - b0 !== 1) begin n_fail++; $display("FAIL rst_nbytes: got %0d expected 1", nbytes - b0); end
        n_checks++; if (cap_byte[b0] !== 8'hDE) begin n_fail++; $display("FAIL rst_byte: got %h expected de", cap_byte[b0]); end
        n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: got %b expected 0", byte_valid); end
    endtask

    task automatic test_counter_wrap();
        int base;
        bit ok;
        do_reset();
        base = n_last;
        for (int i = 0; i < 17; i++) push(32'h01020304 + i);
        En = 1'b1;
        wait_words(15, base, ok);
        n_checks++; if (!ok || word_count !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d expected 15 (done %b)", word_count, ok); end
        wait_words(16, base, ok);
        n_checks++; if (!ok || word_count !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d expected 0 (done %b)", word_count, ok); end
        wait_words(17, base, ok);
        n_checks++; if (!ok || word_count !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d expected 1 (done %b)", word_count, ok); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_idle: busy %b expected 0", busy); end
        En = 1'b0;
    endtask

    task automatic test_no_underflow();
        n_checks++; if (underflow !== 0) begin n_fail++; $display("FAIL underflow: got %0d pops on empty expected 0", underflow); end
    endtask

    initial begin
        Rst = 1'b1;
        En = 1'b0;
        byte_ready = 1'b1;
        dataOut = 32'h0;
        tick();
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_empty_en_gating();
        test_reset_mid_word();
        test_counter_wrap();
        test_no_underflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
